// File: rtl/inst_fetch_buffer.sv
// Purpose: PC consumer; one outstanding instruction read, queues {pc, inst, fault} for decode.
// Latency: aligned pc -> mem_req +1, if_valid one cycle after rvalid; misaligned pc -> if_valid +1.
// Backpressure: pc_ready low while a read is outstanding, the queue is full, or flush is high.
module inst_fetch_buffer #(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_fault
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } entry_t;

    state_t        state;
    logic [31:0]   addr_q;
    logic          discard;
    logic [CW-1:0] count;
    entry_t        push_dat;
    entry_t        head_dat;
    logic          accept;
    logic          misaligned;
    logic          push_mis;
    logic          push_mem;
    logic          push;
    logic          pop;

    assign pc_ready   = (state == IDLE) && (count < CW'(DEPTH)) && !flush;
    assign accept     = pc_valid && pc_ready;
    assign misaligned = (pc[1:0] != 2'b00);
    assign push_mis   = accept && misaligned;
    // A response that raced a redirect belongs to the old path and is dropped.
    assign push_mem   = (state == WAIT) && mem_rvalid && !discard && !flush;
    assign push       = push_mis || push_mem;
    assign if_valid   = (count != '0);
    assign pop        = if_valid && if_ready && !flush;
    assign mem_addr   = addr_q;

    always_comb begin
        push_dat = '0;
        if (push_mis) begin
            push_dat.pc    = pc;
            push_dat.fault = 1'b1;
        end else begin
            push_dat.pc   = addr_q;
            push_dat.inst = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= RESET_ADDR;
            discard <= 1'b0;
            mem_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= pc;
                        if (!misaligned) begin
                            state   <= REQ;
                            mem_req <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state   <= WAIT;
                        mem_req <= 1'b0;
                        discard <= flush;
                    end else if (flush) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state   <= IDLE;
                        discard <= 1'b0;
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(DEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count)
    );

    assign if_pc    = if_valid ? head_dat.pc    : 32'h0;
    assign if_inst  = if_valid ? head_dat.inst  : 32'h0;
    assign if_fault = if_valid ? head_dat.fault : 1'b0;
endmodule

// Purpose: generic circular FIFO with synchronous flush; head word presented combinationally.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: none internal; caller must not push when full nor pop when empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    // Flush wins over any push or pop requested in the same cycle.
    assign do_push  = push && !flush;
    assign do_pop   = pop && !flush;
    assign head_dat = mem[head];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule
